// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, branch/call/return resolution through
// run-time writable target tables, and a hardware return-address stack.
module fetch_unit #(
    parameter int PC_W      = 16,
    parameter int IDX_W     = 5,
    parameter int RAS_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             br_rel_z,
    input  logic             br_rel_nz,
    input  logic             br_abs,
    input  logic             call,
    input  logic             ret,
    input  logic             halt,
    input  logic             zero_flag,
    input  logic [IDX_W-1:0] lut_idx,
    input  logic             lut_we,
    input  logic             lut_wsel,
    input  logic [IDX_W-1:0] lut_widx,
    input  logic [PC_W-1:0]  lut_wdata,
    output logic [PC_W-1:0]  pc,
    output logic             done,
    output logic             ras_ovf,
    output logic             ras_unf
);

    localparam int SP_W    = $clog2(RAS_DEPTH + 1);
    localparam int ENTRIES = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;

    logic [PC_W-1:0] ras_q      [RAS_DEPTH];
    logic [PC_W-1:0] relTable_q [ENTRIES];
    logic [PC_W-1:0] absTable_q [ENTRIES];

    logic            pushEn;
    logic [PC_W-1:0] popData;
    logic [PC_W-1:0] pcInc;
    logic [PC_W-1:0] relTarget;
    logic [PC_W-1:0] absTarget;
    logic            relTaken;
    logic            stackEmpty;
    logic            stackFull;

    assign pcInc      = pc_q + PC_W'(1);
    assign relTarget  = pc_q + relTable_q[lut_idx];
    assign absTarget  = absTable_q[lut_idx];
    assign relTaken   = (br_rel_z & zero_flag) | (br_rel_nz & ~zero_flag);
    assign stackEmpty = (sp_q == '0);
    assign stackFull  = (sp_q == SP_W'(RAS_DEPTH));

    // The stack pointer counts occupied entries, so the top of stack is entry sp-1.
    always_comb begin
        popData = '0;
        for (int i = 0; i < RAS_DEPTH; i++) begin
            if (sp_q == SP_W'(i + 1)) begin
                popData = ras_q[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        pushEn  = 1'b0;

        unique case (state_q)
            IDLE: begin
                pc_d = '0;
                if (start) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                if (!stall) begin
                    if (halt) begin
                        state_d = DONE;
                    end else if (ret) begin
                        if (!stackEmpty) begin
                            pc_d = popData;
                            sp_d = sp_q - SP_W'(1);
                        end else begin
                            pc_d  = pcInc;
                            unf_d = 1'b1;
                        end
                    end else if (call) begin
                        if (!stackFull) begin
                            pushEn = 1'b1;
                            sp_d   = sp_q + SP_W'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                        pc_d = absTarget;
                    end else if (br_abs) begin
                        pc_d = absTarget;
                    end else if (relTaken) begin
                        pc_d = relTarget;
                    end else begin
                        pc_d = pcInc;
                    end
                end
            end

            DONE: begin
                // Restart wipes the call context so a new run begins clean.
                if (start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    sp_d    = '0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                pc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else if (pushEn) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                if (sp_q == SP_W'(i)) begin
                    ras_q[i] <= pcInc;
                end
            end
        end
    end

    // Table writes ignore state and stall; reads above see the pre-edge contents.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                relTable_q[i] <= '0;
                absTable_q[i] <= '0;
            end
        end else if (lut_we) begin
            if (lut_wsel) begin
                absTable_q[lut_widx] <= lut_wdata;
            end else begin
                relTable_q[lut_widx] <= lut_wdata;
            end
        end
    end

    assign pc      = pc_q;
    assign done    = (state_q == DONE);
    assign ras_ovf = ovf_q;
    assign ras_unf = unf_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed walk through the main scenarios, then a random
// run checked cycle by cycle against a queue-based reference model.
module tb_fetch_unit;

   localparam int PC_W      = 16;
   localparam int IDX_W     = 5;
   localparam int RAS_DEPTH = 4;
   localparam int ENTRIES   = 1 << IDX_W;

   localparam int R_START = 1;
   localparam int R_STALL = 2;
   localparam int R_RELZ  = 4;
   localparam int R_RELNZ = 8;
   localparam int R_ABS   = 16;
   localparam int R_CALL  = 32;
   localparam int R_RET   = 64;
   localparam int R_HALT  = 128;

   logic             CLK = 1'b0;
   logic             reset;
   logic             start, stall, br_rel_z, br_rel_nz, br_abs, call, ret, halt;
   logic             zero_flag;
   logic [IDX_W-1:0] lut_idx;
   logic             lut_we, lut_wsel;
   logic [IDX_W-1:0] lut_widx;
   logic [PC_W-1:0]  lut_wdata;
   logic [PC_W-1:0]  pc;
   logic             done, ras_ovf, ras_unf;

   int errors = 0;
   int checks = 0;

   // Reference model: mode 0 = waiting for start, 1 = executing, 2 = halted.
   int              mMode;
   logic [PC_W-1:0] mPc;
   logic            mOvf, mUnf;
   logic [PC_W-1:0] mStack [$];
   logic [PC_W-1:0] mRel [ENTRIES];
   logic [PC_W-1:0] mAbs [ENTRIES];

   fetch_unit #(.PC_W(PC_W), .IDX_W(IDX_W), .RAS_DEPTH(RAS_DEPTH)) dut (
      .CLK(CLK), .reset(reset), .start(start), .stall(stall),
      .br_rel_z(br_rel_z), .br_rel_nz(br_rel_nz), .br_abs(br_abs),
      .call(call), .ret(ret), .halt(halt), .zero_flag(zero_flag),
      .lut_idx(lut_idx), .lut_we(lut_we), .lut_wsel(lut_wsel),
      .lut_widx(lut_widx), .lut_wdata(lut_wdata),
      .pc(pc), .done(done), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
   );

   // Free-running 10-time-unit clock; rising edge is active.
   always #5 CLK = ~CLK;

   // Return the model to its power-on state, tables included.
   task automatic modelReset();
      mMode = 0;
      mPc   = '0;
      mOvf  = 1'b0;
      mUnf  = 1'b0;
      mStack.delete();
      for (int i = 0; i < ENTRIES; i++) begin
         mRel[i] = '0;
         mAbs[i] = '0;
      end
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic modelStep();
      logic [PC_W-1:0] relEntry;
      logic [PC_W-1:0] absEntry;
      relEntry = mRel[lut_idx];
      absEntry = mAbs[lut_idx];
      if (mMode == 0) begin
         if (start) begin
            mMode = 1;
            mPc   = '0;
         end
      end else if (mMode == 1) begin
         if (!stall) begin
            if (halt) begin
               mMode = 2;
            end else if (ret) begin
               if (mStack.size() > 0) begin
                  mPc = mStack.pop_back();
               end else begin
                  mPc  = mPc + 16'd1;
                  mUnf = 1'b1;
               end
            end else if (call) begin
               if (mStack.size() < RAS_DEPTH) mStack.push_back(mPc + 16'd1);
               else mOvf = 1'b1;
               mPc = absEntry;
            end else if (br_abs) begin
               mPc = absEntry;
            end else if ((br_rel_z && zero_flag) || (br_rel_nz && !zero_flag)) begin
               mPc = mPc + relEntry;
            end else begin
               mPc = mPc + 16'd1;
            end
         end
      end else begin
         if (start) begin
            mMode = 1;
            mPc   = '0;
            mOvf  = 1'b0;
            mUnf  = 1'b0;
            mStack.delete();
         end
      end
      if (lut_we) begin
         if (lut_wsel) mAbs[lut_widx] = lut_wdata;
         else mRel[lut_widx] = lut_wdata;
      end
   endtask

   // Drive the request inputs from a bit mask of R_* codes.
   task automatic applyStimulus(input int req, input logic zf, input logic [IDX_W-1:0] idx);
      start     = (req & R_START) != 0;
      stall     = (req & R_STALL) != 0;
      br_rel_z  = (req & R_RELZ)  != 0;
      br_rel_nz = (req & R_RELNZ) != 0;
      br_abs    = (req & R_ABS)   != 0;
      call      = (req & R_CALL)  != 0;
      ret       = (req & R_RET)   != 0;
      halt      = (req & R_HALT)  != 0;
      zero_flag = zf;
      lut_idx   = idx;
   endtask

   // Compare every output against the model.
   task automatic checkOutput(input string tag);
      logic expDone;
      expDone = (mMode == 2);
      checks++;
      assert (pc === mPc) else begin
         errors++;
         $error("[TB] FAIL %s pc: got %0d expected %0d", tag, pc, mPc);
      end
      checks++;
      assert (done === expDone) else begin
         errors++;
         $error("[TB] FAIL %s done: got %b expected %b", tag, done, expDone);
      end
      checks++;
      assert (ras_ovf === mOvf) else begin
         errors++;
         $error("[TB] FAIL %s ras_ovf: got %b expected %b", tag, ras_ovf, mOvf);
      end
      checks++;
      assert (ras_unf === mUnf) else begin
         errors++;
         $error("[TB] FAIL %s ras_unf: got %b expected %b", tag, ras_unf, mUnf);
      end
   endtask

   // Compare the PC against a hand-derived value from the scenario description.
   task automatic checkPc(input string tag, input logic [PC_W-1:0] expPc);
      checks++;
      assert (pc === expPc) else begin
         errors++;
         $error("[TB] FAIL %s pc: got %0d expected %0d", tag, pc, expPc);
      end
   endtask

   task automatic checkBit(input string tag, input logic got, input logic expBit);
      checks++;
      assert (got === expBit) else begin
         errors++;
         $error("[TB] FAIL %s: got %b expected %b", tag, got, expBit);
      end
   endtask

   task automatic tick(input string tag);
      modelStep();
      @(posedge CLK);
      #1;
      checkOutput(tag);
   endtask

   task automatic step(input int req, input logic zf, input logic [IDX_W-1:0] idx, input string tag);
      applyStimulus(req, zf, idx);
      tick(tag);
   endtask

   task automatic writeLut(input logic sel, input logic [IDX_W-1:0] idx, input logic [PC_W-1:0] data);
      lut_we    = 1'b1;
      lut_wsel  = sel;
      lut_widx  = idx;
      lut_wdata = data;
      step(0, 1'b0, '0, "lut write");
      lut_we = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      lut_we    = 1'b0;
      lut_wsel  = 1'b0;
      lut_widx  = '0;
      lut_wdata = '0;
      applyStimulus(0, 1'b0, '0);
      modelReset();
      #12;
      checkOutput("reset state");
      checkPc("reset pc", 16'd0);
      reset = 1'b0;

      writeLut(1'b0, 5'd3, 16'hFFFE);
      writeLut(1'b1, 5'd1, 16'd40);
      for (int k = 0; k < 5; k++) writeLut(1'b1, IDX_W'(4 + k), PC_W'(100 * (k + 1)));

      step(R_START, 1'b0, '0, "start");
      checkPc("start pc", 16'd0);
      for (int k = 0; k < 5; k++) step(0, 1'b0, '0, "sequential");
      checkPc("sequential 5", 16'd5);

      step(R_CALL, 1'b0, 5'd1, "call");
      checkPc("call to 40", 16'd40);
      step(0, 1'b0, '0, "in sub");
      step(0, 1'b0, '0, "in sub");
      step(R_RET, 1'b0, '0, "ret");
      checkPc("ret to 6", 16'd6);
      step(R_RELNZ, 1'b0, 5'd3, "rel back");
      step(0, 1'b0, '0, "inc");
      step(R_CALL, 1'b0, 5'd1, "call again");
      step(R_CALL | R_RET, 1'b0, 5'd1, "call+ret");
      checkPc("ret wins", 16'd6);

      for (int k = 0; k < 4; k++) step(0, 1'b0, '0, "inc");
      checkPc("reach 10", 16'd10);
      step(R_RELNZ, 1'b0, 5'd3, "rel nz taken");
      checkPc("rel nz taken", 16'd8);
      step(R_RELNZ, 1'b1, 5'd3, "rel nz not taken");
      checkPc("rel nz not taken", 16'd9);

      for (int k = 0; k < 5; k++) begin
         step(R_CALL, 1'b0, IDX_W'(4 + k), "nested call");
         if (k == 3) checkBit("ovf after 4th call", ras_ovf, 1'b0);
      end
      checkBit("ovf after 5th call", ras_ovf, 1'b1);
      checkPc("5th call target", 16'd500);
      for (int k = 0; k < 5; k++) begin
         step(R_RET, 1'b0, '0, "nested ret");
         if (k == 3) checkPc("4th ret", 16'd10);
      end
      checkBit("unf after 5th ret", ras_unf, 1'b1);
      checkPc("5th ret increments", 16'd11);

      for (int k = 0; k < 3; k++) step(R_STALL | R_HALT, 1'b0, '0, "stalled halt");
      checkPc("stall holds", 16'd11);
      checkBit("stall no done", done, 1'b0);
      step(R_HALT, 1'b0, '0, "halt");
      checkBit("halt done", done, 1'b1);
      step(R_CALL, 1'b0, 5'd1, "done frozen");
      checkPc("done frozen", 16'd11);
      step(R_START, 1'b0, '0, "restart");
      checkPc("restart pc", 16'd0);
      checkBit("restart done", done, 1'b0);
      checkBit("restart ovf", ras_ovf, 1'b0);
      checkBit("restart unf", ras_unf, 1'b0);

      $display("[TB] directed phase complete, starting random phase");
      for (int n = 0; n < 1500; n++) begin
         int req;
         req = 0;
         if ($urandom_range(0, 7) == 0)  req |= R_START;
         if ($urandom_range(0, 5) == 0)  req |= R_STALL;
         if ($urandom_range(0, 4) == 0)  req |= R_RELZ;
         if ($urandom_range(0, 4) == 0)  req |= R_RELNZ;
         if ($urandom_range(0, 7) == 0)  req |= R_ABS;
         if ($urandom_range(0, 6) == 0)  req |= R_CALL;
         if ($urandom_range(0, 6) == 0)  req |= R_RET;
         if ($urandom_range(0, 39) == 0) req |= R_HALT;
         applyStimulus(req, 1'($urandom_range(0, 1)), IDX_W'($urandom_range(0, 7)));
         lut_we    = ($urandom_range(0, 3) == 0);
         lut_wsel  = 1'($urandom_range(0, 1));
         lut_widx  = IDX_W'($urandom_range(0, 7));
         lut_wdata = ($urandom_range(0, 1) == 0) ? PC_W'($urandom) : PC_W'($urandom_range(0, 8) - 4);
         tick("random");
      end
      lut_we = 1'b0;

      step(R_HALT, 1'b0, '0, "pre-reset halt");
      step(R_START, 1'b0, '0, "pre-reset start");
      for (int k = 0; k < 37; k++) step(0, 1'b0, '0, "count to 37");
      checkPc("reach 37", 16'd37);
      #3;
      reset = 1'b1;
      #1;
      modelReset();
      checkOutput("async reset");
      checkPc("async reset pc", 16'd0);
      #2;
      reset = 1'b0;
      step(R_START, 1'b0, '0, "post-reset start");
      step(R_ABS, 1'b0, 5'd1, "abs table cleared");
      checkPc("abs table cleared", 16'd0);
      step(0, 1'b0, '0, "inc");
      step(R_RELZ, 1'b1, 5'd3, "rel table cleared");
      checkPc("rel table cleared", 16'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage for the 9-bit-instruction processor: holds the program counter, resolves the next PC from the controller's branch/call/return/halt requests, and raises `done` at program end. Branch targets come from run-time writable relative/absolute target tables instead of fixed constants. A hardware return-address stack supports function call/return. Sits between the control decoder and `InstROM`; `pc` drives the ROM address directly.

## Interface
Parameters:
- `PC_W`, 16, width of PC, table entries and stack entries
- `IDX_W`, 5, target-table index width; each table has 2^IDX_W entries
- `RAS_DEPTH`, 4, return-address stack entries (≥1)

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  begin execution at PC 0 (honoured in IDLE and DONE only)
- `stall`  in  1  freeze PC, stack and state this cycle
- `br_rel_z`  in  1  relative branch if `zero_flag`=1
- `br_rel_nz`  in  1  relative branch if `zero_flag`=0
- `br_abs`  in  1  unconditional absolute jump
- `call`  in  1  push return address, jump absolute
- `ret`  in  1  pop return address, jump to it
- `halt`  in  1  end of program
- `zero_flag`  in  1  registered ALU zero flag
- `lut_idx`  in  IDX_W  target-table index for the current request
- `lut_we`  in  1  table write enable
- `lut_wsel`  in  1  0 = relative table, 1 = absolute table
- `lut_widx`  in  IDX_W  write index
- `lut_wdata`  in  PC_W  write data (relative entries are two's complement)
- `pc`  out  PC_W  current PC
- `done`  out  1  program halted
- `ras_ovf`  out  1  sticky: call with stack full
- `ras_unf`  out  1  sticky: ret with stack empty

## Operation
- States: IDLE, RUN, DONE.
- Reset values:
  - state = IDLE, `pc` = 0, `done` = 0, `ras_ovf` = `ras_unf` = 0.
  - Stack pointer = 0 (empty).
  - All table entries = 0.
- IDLE:
  - `pc` held at 0.
  - `start`=1 → RUN.
- RUN, `stall`=1: nothing changes, including on `halt`, `call` and `ret`.
- RUN, `stall`=0: next PC chosen by fixed priority:
  1. `halt`: state → DONE, `pc` held.
  2. `ret`:
     - Stack non-empty: pop; `pc` ← popped value.
     - Stack empty: `pc` ← `pc`+1; set `ras_unf`.
  3. `call`:
     - Stack not full: push `pc`+1.
     - Stack full: no push; set `ras_ovf`.
     - In both cases `pc` ← abs[`lut_idx`].
  4. `br_abs`: `pc` ← abs[`lut_idx`].
  5. `br_rel_z` with `zero_flag`=1, or `br_rel_nz` with `zero_flag`=0: `pc` ← `pc` + rel[`lut_idx`].
  6. Otherwise, including a branch whose condition fails: `pc` ← `pc`+1.
- `start` in RUN is ignored.
- DONE:
  - `pc` held.
  - `start`=1 → RUN with `pc` ← 0, stack emptied, `ras_ovf`/`ras_unf` cleared.
  - Table contents are retained.
- Arithmetic: all PC additions are modulo 2^PC_W, so wrap-around is silent. `pc`+1 at all-ones gives 0. A relative add below 0 wraps.
- Tables:
  - Reads are combinational.
  - Writes occur at the clock edge whenever `lut_we`=1, in any state and regardless of `stall`.
  - A write and a read of the same entry in the same cycle return the old value.
- Stack: LIFO, depth RAS_DEPTH. `ret` and `call` never both take effect, because `ret` has priority.

## Timing
- `pc` and `done` are registered. The next PC is combinational from the current-cycle inputs and appears one cycle later.
- Start latency: `start` in IDLE at edge N → state RUN after edge N, `pc`=0. The first advance happens at edge N+1.
- Halt latency: `halt` sampled at edge N → `done`=1 after edge N.
- Restart from DONE: `done` falls at the same edge that resets `pc` to 0.
- A `reset` assertion at any time, including mid-program, immediately forces all outputs to their reset values. No edge is needed.
- Error flags update at the same edge as the offending `call` or `ret`. They stay set until reset or restart.

## Test plan
- Reset, then `start`; run 5 cycles with no requests → `pc` sequence 0,1,2,3,4,5 and `done`=0.
- Program rel[3]=-2 (16'hFFFE), reach `pc`=10:
  - `br_rel_nz`, `lut_idx`=3, `zero_flag`=0 → `pc`=8.
  - Same request with `zero_flag`=1 → `pc`=9.
- abs[1]=40:
  - At `pc`=5, `call` `lut_idx`=1 → `pc`=40.
  - Later `ret` → `pc`=6.
  - `call` and `ret` together at `pc`=40 → `ret` wins, `pc`=6.
- RAS_DEPTH=4: five nested calls → `ras_ovf`=1 after the 5th; five `ret`s → four correct returns, then `ras_unf`=1 and `pc` incremented.
- `stall` held 3 cycles with `halt` asserted → `pc` unchanged and `done`=0. Release → `done`=1 next edge, `pc` frozen. `start` → `pc`=0, `done`=0, flags cleared.
- Reset asserted between edges mid-run (`pc`=37) → `pc`=0 and `done`=0 immediately. Table entries read back as 0.
